// File: rtl/cnt32_rd_resp.sv
// rtl/cnt32_rd_resp.sv - CPU read responder for a bank of 32-bit statistics counters
// Optional clear-on-read of the selected counter: define CNT_RD_CLR_EN.
module cnt32_rd_resp #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          CNT_NUM    = 8,
  parameter logic [12:0] BASE_ADDR  = 13'h100,
  parameter logic [12:0] CLR_ADDR   = 13'h0FF,
  parameter logic [31:0] MISS_DATA  = 32'hDEAD_BEEF
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_rd_ack,
  output logic [31:0]           cpu_rd_data,
  output logic                  cpu_rd_miss,
  input  logic [CNT_NUM*32-1:0] cnt_din,
  output logic [CNT_NUM-1:0]    cnt_clr
);

  localparam int IDX_W = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [31:0]         data_q, data_d;
  logic                miss_q, miss_d;
  logic                ack_q, ack_d;
  logic [CNT_NUM-1:0]  clr_q, clr_d;

  // Offset is computed at address width so that addresses below the base wrap
  // to a large value and fail the range check.
  logic [ADDR_WIDTH-1:0] addr_off;
  logic                  addr_hit;
  logic [31:0]           cnt_sel;

  assign addr_off = cpu_addr - ADDR_WIDTH'(BASE_ADDR);
  assign addr_hit = (cpu_addr >= ADDR_WIDTH'(BASE_ADDR)) &&
                    (addr_off < ADDR_WIDTH'(CNT_NUM));
  assign cnt_sel  = cnt_din[{idx_q, 5'd0} +: 32];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    data_d  = data_q;
    miss_d  = miss_q;
    ack_d   = 1'b0;
    clr_d   = '0;
    case (state_q)
      IDLE: begin
        if (cpu_rd) begin
          idx_d   = addr_off[IDX_W-1:0];
          hit_d   = addr_hit;
          state_d = LATCH;
`ifdef CNT_RD_CLR_EN
          // Clear lands on the same edge that snapshots the pre-clear value.
          if (addr_hit) clr_d[addr_off[IDX_W-1:0]] = 1'b1;
`endif
        end else if (cpu_wr && (cpu_addr == ADDR_WIDTH'(CLR_ADDR))) begin
          clr_d = '1;
        end
      end
      LATCH: begin
        data_d  = hit_q ? cnt_sel : MISS_DATA;
        miss_d  = ~hit_q;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      data_q  <= '0;
      miss_q  <= 1'b0;
      ack_q   <= 1'b0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      data_q  <= data_d;
      miss_q  <= miss_d;
      ack_q   <= ack_d;
      clr_q   <= clr_d;
    end
  end

  assign cpu_rd_ack  = ack_q;
  assign cpu_rd_data = data_q;
  assign cpu_rd_miss = miss_q;
  assign cnt_clr     = clr_q;

endmodule

// File: tb/tb_cnt32_rd_resp.sv
// tb/tb_cnt32_rd_resp.sv - directed self-checking bench for cnt32_rd_resp
module tb_cnt32_rd_resp;

  logic         clks;
  logic         reset;
  logic         cpu_rd;
  logic         cpu_wr;
  logic [12:0]  cpu_addr;
  logic         cpu_rd_ack;
  logic [31:0]  cpu_rd_data;
  logic         cpu_rd_miss;
  logic [255:0] cnt_din;
  logic [7:0]   cnt_clr;

  int n_checks = 0;
  int n_fail   = 0;

  cnt32_rd_resp dut (
    .clks        (clks),
    .reset       (reset),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_rd_ack  (cpu_rd_ack),
    .cpu_rd_data (cpu_rd_data),
    .cpu_rd_miss (cpu_rd_miss),
    .cnt_din     (cnt_din),
    .cnt_clr     (cnt_clr)
  );

  initial clks = 1'b0;
  always #5 clks = ~clks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge, mid-cycle.
  task automatic rd_txn(input logic [12:0] addr, input logic [31:0] exp_d,
                        input logic exp_m, input logic [7:0] exp_clr, input string tag);
    @(negedge clks);
    cpu_rd = 1'b1; cpu_addr = addr;
    @(negedge clks);
    cpu_rd = 1'b0;
    chk({tag, " clr T1"}, 32'(cnt_clr), 32'(exp_clr));
    chk({tag, " ack T1"}, 32'(cpu_rd_ack), 32'd0);
    @(negedge clks);
    chk({tag, " ack T2"}, 32'(cpu_rd_ack), 32'd1);
    chk({tag, " data T2"}, cpu_rd_data, exp_d);
    chk({tag, " miss T2"}, 32'(cpu_rd_miss), 32'(exp_m));
    chk({tag, " clr T2"}, 32'(cnt_clr), 32'd0);
    @(negedge clks);
    chk({tag, " ack T3"}, 32'(cpu_rd_ack), 32'd0);
  endtask

  logic [7:0] exp_rc_clr;
  int         acks;

  initial begin
    reset = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h100;
    for (int i = 0; i < 8; i++) cnt_din[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    cnt_din[3*32 +: 32] = 32'h1234_5678;
    cnt_din[5*32 +: 32] = 32'hFFFF_FFFF;
`ifdef CNT_RD_CLR_EN
    exp_rc_clr = 8'h20;
`else
    exp_rc_clr = 8'h00;
`endif

    // Reset held with a read request pending
    for (int k = 0; k < 4; k++) begin
      @(negedge clks);
      chk("reset ack", 32'(cpu_rd_ack), 32'd0);
      chk("reset data", cpu_rd_data, 32'd0);
      chk("reset clr", 32'(cnt_clr), 32'd0);
    end
    cpu_rd = 1'b0;
    reset  = 1'b1;

    rd_txn(13'h103, 32'h1234_5678, 1'b0, 8'h00, "hit 103");
    rd_txn(13'h0FE, 32'hDEAD_BEEF, 1'b1, 8'h00, "miss 0FE");
    rd_txn(13'h108, 32'hDEAD_BEEF, 1'b1, 8'h00, "miss 108");
    rd_txn(13'h107, 32'hA000_0007, 1'b0, 8'h00, "hit 107");
    rd_txn(13'h000, 32'hDEAD_BEEF, 1'b1, 8'h00, "miss 000");

    // Held read: acks at T2, T5, T8 only
    @(negedge clks);
    cpu_rd = 1'b1; cpu_addr = 13'h100;
    acks = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b2b ack T%0d", k), 32'(cpu_rd_ack), 32'((k % 3) == 2));
      if (cpu_rd_ack) begin
        acks++;
        chk($sformatf("b2b data T%0d", k), cpu_rd_data, 32'hA000_0000);
      end
      @(negedge clks);
    end
    cpu_rd = 1'b0;
    chk("b2b ack count", 32'(acks), 32'd3);
    chk("b2b ack T9", 32'(cpu_rd_ack), 32'd0);

    // Clear-all write
    @(negedge clks);
    cpu_wr = 1'b1; cpu_addr = 13'h0FF;
    @(negedge clks);
    cpu_wr = 1'b0;
    chk("clrall clr T1", 32'(cnt_clr), 32'hFF);
    chk("clrall ack T1", 32'(cpu_rd_ack), 32'd0);
    @(negedge clks);
    chk("clrall clr T2", 32'(cnt_clr), 32'd0);
    chk("clrall ack T2", 32'(cpu_rd_ack), 32'd0);

    // Write to a non-clear address does nothing
    cpu_wr = 1'b1; cpu_addr = 13'h100;
    @(negedge clks);
    cpu_wr = 1'b0;
    chk("wr other clr", 32'(cnt_clr), 32'd0);
    @(negedge clks);
    chk("wr other ack", 32'(cpu_rd_ack), 32'd0);

    // Read and write together: read wins, no clear
    cpu_wr = 1'b1;
    rd_txn(13'h0FF, 32'hDEAD_BEEF, 1'b1, 8'h00, "rd+wr");
    cpu_wr = 1'b0;

    rd_txn(13'h105, 32'hFFFF_FFFF, 1'b0, exp_rc_clr, "rdclr 105");

    // Reset pulse in T1 aborts the transaction
    @(negedge clks);
    cpu_rd = 1'b1; cpu_addr = 13'h105;
    @(negedge clks);
    cpu_rd = 1'b0;
    reset  = 1'b0;
    #2;
    chk("abort clr", 32'(cnt_clr), 32'd0);
    reset  = 1'b1;
    @(negedge clks);
    chk("abort ack T2", 32'(cpu_rd_ack), 32'd0);
    chk("abort data T2", cpu_rd_data, 32'd0);
    @(negedge clks);
    chk("abort ack T3", 32'(cpu_rd_ack), 32'd0);

    rd_txn(13'h103, 32'h1234_5678, 1'b0, 8'h00, "post abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
